// File: rtl/decoder_3to8_pkg.sv
// Shared constants and helpers for the registered binary-to-one-hot decoder.
// Consumed by decoder_3to8_comb and by the optional checker in decoder_3to8.
package decoder_3to8_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DEF_OUT_W  = 1 << ADDR_W_DEF;
    localparam int MAX_OUT_W  = 64;

    function automatic logic [DEF_OUT_W-1:0] onehot_dec(
        input logic                  en,
        input logic [ADDR_W_DEF-1:0] sel
    );
        logic [DEF_OUT_W-1:0] dec;
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
        return dec;
    endfunction

    // Callers zero-extend narrower vectors to the widest legal output width.
    function automatic logic is_onehot(input logic [MAX_OUT_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/decoder_3to8_comb.sv
// Purely combinational enable/select decode feeding the output register.
module decoder_3to8_comb
    import decoder_3to8_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 E,
    input  logic [ADDR_W-1:0]    A,
    output logic [2**ADDR_W-1:0] y_next
);

    // The package helper is sized for the default width; other widths decode inline.
    if (ADDR_W == ADDR_W_DEF) begin : g_def
        assign y_next = onehot_dec(E, A);
    end else begin : g_gen
        for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_bit
            assign y_next[i] = E && (A == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/decoder_3to8.sv
// Registered one-hot decoder with enable and valid flag.
// Define DECODER_3TO8_ONEHOT_CHK_EN to add the sticky err output and assertion.
module decoder_3to8
    import decoder_3to8_pkg::*;
#(
    parameter int                   ADDR_W = ADDR_W_DEF,
    parameter logic [2**ADDR_W-1:0] Y_RST  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 E,
    input  logic [ADDR_W-1:0]    A,
    output logic [2**ADDR_W-1:0] Y,
    output logic                 Y_vld
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
    ,
    output logic                 err
`endif
);

    localparam int OUT_W = 2**ADDR_W;

    logic [OUT_W-1:0] y_next;

    decoder_3to8_comb #(
        .ADDR_W (ADDR_W)
    ) u_comb (
        .E      (E),
        .A      (A),
        .y_next (y_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y     <= Y_RST;
            Y_vld <= 1'b0;
        end else begin
            Y     <= y_next;
            Y_vld <= E;
        end
    end

`ifdef DECODER_3TO8_ONEHOT_CHK_EN
    logic [MAX_OUT_W-1:0] y_ext;
    logic                 bad;

    always_comb begin
        y_ext            = '0;
        y_ext[OUT_W-1:0] = Y;
        bad              = Y_vld ? !is_onehot(y_ext) : (y_ext != '0);
    end

    // Sticky until reset so a single bad cycle is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bad) begin
            err <= 1'b1;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst) !bad);
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: directed scenarios plus random traffic
// compared against an arithmetic reference model (Y = E ? 1<<A : 0, one cycle later).
module tb_decoder_3to8;

    localparam int ADDR_W = 3;
    localparam int OUT_W  = 8;

    logic              clk;
    logic              rst;
    logic              E;
    logic [ADDR_W-1:0] A;
    logic [OUT_W-1:0]  Y;
    logic              Y_vld;
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
    logic              err;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    decoder_3to8 #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .E     (E),
        .A     (A),
        .Y     (Y),
        .Y_vld (Y_vld)
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
        ,
        .err   (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] model_y(input logic en, input int sel);
        return en ? OUT_W'(1 << sel) : '0;
    endfunction

    task automatic drive(input logic en, input logic [ADDR_W-1:0] sel);
        @(negedge clk);
        E = en;
        A = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        E   = 1'b1;
        A   = 3'b101;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (Y !== 8'h00 || Y_vld !== 1'b0)
            $display("FAIL reset_async: Y=%h Y_vld=%b, want 00/0", Y, Y_vld);
        else
            pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (Y !== 8'h00 || Y_vld !== 1'b0)
                $display("FAIL reset_hold[%0d]: Y=%h Y_vld=%b, want 00/0", i, Y, Y_vld);
            else
                pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (Y !== 8'h20 || Y_vld !== 1'b1)
            $display("FAIL reset_first_decode: Y=%h Y_vld=%b, want 20/1", Y, Y_vld);
        else
            pass_cnt++;
    endtask

    task automatic test_disabled();
        drive(1'b0, 3'b000);
        total_cnt++;
        if (Y !== 8'h00 || Y_vld !== 1'b0)
            $display("FAIL disabled_a0: Y=%h Y_vld=%b, want 00/0", Y, Y_vld);
        else
            pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, ADDR_W'($urandom_range(0, OUT_W - 1)));
            total_cnt++;
            if (Y !== 8'h00 || Y_vld !== 1'b0)
                $display("FAIL disabled_rand A=%0d: Y=%h Y_vld=%b, want 00/0", A, Y, Y_vld);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_sweep();
        logic [OUT_W-1:0] want [3] = '{8'h02, 8'h04, 8'h80};
        int               sels [3] = '{1, 2, 7};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADDR_W'(sels[i]));
            total_cnt++;
            if (Y !== want[i] || Y_vld !== 1'b1)
                $display("FAIL sweep A=%0d: Y=%h Y_vld=%b, want %h/1", sels[i], Y, Y_vld, want[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < OUT_W; a++) begin
            drive(1'b1, ADDR_W'(a));
            total_cnt++;
            if (Y !== model_y(1'b1, a) || Y_vld !== 1'b1)
                $display("FAIL exhaustive A=%0d: Y=%h Y_vld=%b, want %h/1",
                         a, Y, Y_vld, model_y(1'b1, a));
            else
                pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic en;
        int   sel;
        for (int i = 0; i < 200; i++) begin
            en  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, OUT_W - 1));
            drive(en, ADDR_W'(sel));
            total_cnt++;
            if (Y !== model_y(en, sel) || Y_vld !== en)
                $display("FAIL random[%0d] E=%b A=%0d: Y=%h Y_vld=%b, want %h/%b",
                         i, en, sel, Y, Y_vld, model_y(en, sel), en);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_midop_reset();
        drive(1'b1, 3'd7);
        total_cnt++;
        if (Y !== 8'h80)
            $display("FAIL midop_pre: Y=%h, want 80", Y);
        else
            pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (Y !== 8'h00 || Y_vld !== 1'b0)
            $display("FAIL midop_async: Y=%h Y_vld=%b, want 00/0", Y, Y_vld);
        else
            pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        E   = 1'b1;
        A   = 3'd3;
        @(posedge clk);
        #1;
        total_cnt++;
        if (Y !== 8'h08 || Y_vld !== 1'b1)
            $display("FAIL midop_after: Y=%h Y_vld=%b, want 08/1", Y, Y_vld);
        else
            pass_cnt++;
    endtask

`ifdef DECODER_3TO8_ONEHOT_CHK_EN
    task automatic test_checker();
        for (int a = 0; a < 2 * OUT_W; a++) begin
            drive(1'(a % 2), ADDR_W'(a / 2));
        end
        total_cnt++;
        if (err !== 1'b0)
            $display("FAIL chk_clean: err=%b, want 0", err);
        else
            pass_cnt++;
        @(negedge clk);
        force dut.Y = 8'h03;
        @(posedge clk);
        #1;
        release dut.Y;
        @(posedge clk);
        #1;
        total_cnt++;
        if (err !== 1'b1)
            $display("FAIL chk_set: err=%b, want 1", err);
        else
            pass_cnt++;
        drive(1'b1, 3'd2);
        total_cnt++;
        if (err !== 1'b1)
            $display("FAIL chk_sticky: err=%b, want 1", err);
        else
            pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (err !== 1'b0)
            $display("FAIL chk_clear: err=%b, want 0", err);
        else
            pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_disabled();
        test_sweep();
        test_back_to_back();
        test_random();
        test_midop_reset();
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
        test_checker();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
